descram_sync_ctrl: RTL and testbench

//  Sequencing and lock controller for the self-synchronising PRBS descrambler (Descram).
//  - Drives the descrambler enable and flushes its shift register.
//  - Monitors the descrambled words. With PRBS payload, a correct word is all-zero.
//  - Declares/loses lock and keeps a saturating error counter for the link monitor.
//  - Sits between the lane word aligner (upstream) and link status/CSR logic (downstream).

---
 rtl/descram_pkg.sv | 25 ++
 rtl/descram_popcnt.sv | 16 +
 rtl/descram_sync_ctrl.sv | 143 ++++++++++++++
 tb/tb_descram_sync_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/descram_pkg.sv
// Shared state encoding and sizing helpers for the descrambler sync controller.
package descram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    HUNT   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  // Words needed to fill the descrambler shift register plus its output register.
  function automatic int flush_len(input int pp, input int dw);
    return (pp + dw - 1) / dw + 1;
  endfunction

  // Bits needed to hold values 0..v-1, never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/descram_popcnt.sv
// Combinational population count of a descrambled word (bit-error count).
module descram_popcnt #(
  parameter int DW = 62,
  parameter int OW = 6
) (
  input  logic [DW-1:0] i_dat,
  output logic [OW-1:0] o_cnt
);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < DW; i++)
      o_cnt = o_cnt + OW'(i_dat[i]);
  end

endmodule

// File: rtl/descram_sync_ctrl.sv
// Descrambler sequencing/lock controller: flush, hunt for all-zero runs, windowed loss detection.
// Define DESCRAM_BER_CNT_EN to count bit errors (popcount) instead of errored words in Err_Cnt.
module descram_sync_ctrl
  import descram_pkg::*;
#(
  parameter int DW       = 62,
  parameter int PP       = 58,
  parameter int LOCK_CNT = 16,
  parameter int WIN      = 64,
  parameter int LOSS_ERR = 4,
  parameter int ECW      = 16
) (
  input  logic          Ck,
  input  logic          Rs,
  input  logic          CE,
  input  logic          Start,
  input  logic          Stop,
  input  logic          Clr,
  input  logic          Vld_i,
  input  logic [DW-1:0] Dat_i,
  output logic          Des_En,
  output logic          Lock,
  output logic          Loss,
  output logic [1:0]    State_o,
  output logic [ECW-1:0] Err_Cnt
);

  logic w_err;
  assign w_err = |Dat_i;

`ifdef DESCRAM_BER_CNT_EN
  localparam int IW = clog2(DW + 1);
  logic [IW-1:0] w_inc;
  descram_popcnt #(.DW(DW), .OW(IW)) u_popcnt (.i_dat(Dat_i), .o_cnt(w_inc));
`else
  localparam int IW = 1;
  logic [IW-1:0] w_inc;
  assign w_inc = w_err;
`endif

  localparam int FLUSH_N = flush_len(PP, DW);
  localparam int FW = clog2(FLUSH_N);
  localparam int ZW = clog2(LOCK_CNT + 1);
  localparam int WW = clog2(WIN);
  localparam int BW = clog2(LOSS_ERR + 1);
  localparam int SW = ((ECW > IW) ? ECW : IW) + 1;
  localparam logic [ECW-1:0] ERR_MAX = '1;

  state_t        r_state, w_state;
  logic [FW-1:0] r_flush_cnt, w_flush_cnt;
  logic [ZW-1:0] r_zero_cnt, w_zero_cnt;
  logic [WW-1:0] r_win_cnt, w_win_cnt;
  logic [BW-1:0] r_bad_cnt, w_bad_cnt, w_bad_sum;
  logic          r_loss, w_loss;
  logic [ECW-1:0] r_err_cnt, w_err_cnt;
  logic [SW-1:0] w_err_sum;

  always_comb begin
    w_state     = r_state;
    w_flush_cnt = r_flush_cnt;
    w_zero_cnt  = r_zero_cnt;
    w_win_cnt   = r_win_cnt;
    w_bad_cnt   = r_bad_cnt;
    w_loss      = 1'b0;
    w_err_cnt   = r_err_cnt;
    w_bad_sum   = r_bad_cnt + BW'(w_err);
    w_err_sum   = SW'(r_err_cnt) + SW'(w_inc);
    case (r_state)
      IDLE: if (Start) begin
        w_state     = FLUSH;
        w_flush_cnt = '0;
      end
      FLUSH: if (Vld_i) begin
        if (r_flush_cnt == FW'(FLUSH_N - 1)) begin
          w_state    = HUNT;
          w_zero_cnt = '0;
        end else begin
          w_flush_cnt = r_flush_cnt + FW'(1);
        end
      end
      HUNT: if (Vld_i) begin
        if (w_err) begin
          w_zero_cnt = '0;
        end else begin
          w_zero_cnt = r_zero_cnt + ZW'(1);
          if (w_zero_cnt == ZW'(LOCK_CNT)) begin
            w_state   = LOCKED;
            w_win_cnt = '0;
            w_bad_cnt = '0;
          end
        end
      end
      LOCKED: if (Vld_i) begin
        // Loss takes precedence over a window ending on the same word.
        if (w_bad_sum >= BW'(LOSS_ERR)) begin
          w_state    = HUNT;
          w_loss     = 1'b1;
          w_zero_cnt = '0;
        end else if (r_win_cnt == WW'(WIN - 1)) begin
          w_win_cnt = '0;
          w_bad_cnt = '0;
        end else begin
          w_win_cnt = r_win_cnt + WW'(1);
          w_bad_cnt = w_bad_sum;
        end
        w_err_cnt = (w_err_sum > SW'(ERR_MAX)) ? ERR_MAX : ECW'(w_err_sum);
      end
      default: w_state = IDLE;
    endcase
    if (Clr) w_err_cnt = '0;
    if (Stop) begin
      w_state = IDLE;
      w_loss  = 1'b0;
    end
  end

  always_ff @(posedge Ck) begin
    if (!Rs) begin
      r_state     <= IDLE;
      r_flush_cnt <= '0;
      r_zero_cnt  <= '0;
      r_win_cnt   <= '0;
      r_bad_cnt   <= '0;
      r_loss      <= 1'b0;
      r_err_cnt   <= '0;
    end else if (CE) begin
      r_state     <= w_state;
      r_flush_cnt <= w_flush_cnt;
      r_zero_cnt  <= w_zero_cnt;
      r_win_cnt   <= w_win_cnt;
      r_bad_cnt   <= w_bad_cnt;
      r_loss      <= w_loss;
      r_err_cnt   <= w_err_cnt;
    end
  end

  assign Des_En  = (r_state != IDLE);
  assign Lock    = (r_state == LOCKED);
  assign Loss    = r_loss;
  assign State_o = r_state;
  assign Err_Cnt = r_err_cnt;

endmodule

// File: tb/tb_descram_sync_ctrl.sv
// Self-checking bench: two controllers (default, and ECW=4 with loss disabled) against a queue-based model.
module tb_descram_sync_ctrl;

  localparam int DW = 62;
  localparam int PP = 58;
  localparam int LOCK = 16;
  localparam int WIN = 64;
  localparam int FLUSH_W = (PP + DW - 1) / DW + 1;
`ifdef DESCRAM_BER_CNT_EN
  localparam bit BER = 1'b1;
`else
  localparam bit BER = 1'b0;
`endif
  localparam longint INC3 = BER ? 2 : 1;

  logic Ck = 1'b0;
  always #5 Ck = ~Ck;

  logic Rs, CE, Start, Stop, Clr, Vld_i;
  logic [DW-1:0] Dat_i;
  logic a_en, a_lock, a_loss, b_en, b_lock, b_loss;
  logic [1:0] a_st, b_st;
  logic [15:0] a_err;
  logic [3:0] b_err;

  descram_sync_ctrl #(.DW(DW), .PP(PP), .LOCK_CNT(LOCK), .WIN(WIN), .LOSS_ERR(4), .ECW(16)) u_a (
    .Ck(Ck), .Rs(Rs), .CE(CE), .Start(Start), .Stop(Stop), .Clr(Clr), .Vld_i(Vld_i), .Dat_i(Dat_i),
    .Des_En(a_en), .Lock(a_lock), .Loss(a_loss), .State_o(a_st), .Err_Cnt(a_err));

  descram_sync_ctrl #(.DW(DW), .PP(PP), .LOCK_CNT(LOCK), .WIN(WIN), .LOSS_ERR(64), .ECW(4)) u_b (
    .Ck(Ck), .Rs(Rs), .CE(CE), .Start(Start), .Stop(Stop), .Clr(Clr), .Vld_i(Vld_i), .Dat_i(Dat_i),
    .Des_En(b_en), .Lock(b_lock), .Loss(b_loss), .State_o(b_st), .Err_Cnt(b_err));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run history kept as queues of per-word error flags.
  int     m_st[2];
  int     m_fl[2];
  bit     m_loss[2];
  longint m_err[2];
  bit     hq[2][$];
  bit     wq[2][$];
  int     P_LOSS[2] = '{4, 64};
  longint P_MAX[2]  = '{65535, 15};

  function automatic int qones(input bit q[$]);
    int n = 0;
    foreach (q[i]) n += int'(q[i]);
    return n;
  endfunction

  task automatic mdl_step(input int k);
    int nxt;
    bit e;
    longint inc;
    if (!Rs) begin
      m_st[k] = 0; m_fl[k] = 0; m_loss[k] = 0; m_err[k] = 0;
      hq[k].delete(); wq[k].delete();
      return;
    end
    if (!CE) return;
    e = (Dat_i != '0);
    inc = BER ? longint'($countones(Dat_i)) : longint'(e);
    m_loss[k] = 0;
    nxt = m_st[k];
    if (m_st[k] == 3 && Vld_i)
      m_err[k] = (m_err[k] + inc > P_MAX[k]) ? P_MAX[k] : m_err[k] + inc;
    if (Clr) m_err[k] = 0;
    case (m_st[k])
      0: if (Start) begin nxt = 1; m_fl[k] = 0; end
      1: if (Vld_i) begin
        m_fl[k]++;
        if (m_fl[k] == FLUSH_W) begin nxt = 2; hq[k].delete(); end
      end
      2: if (Vld_i) begin
        hq[k].push_back(e);
        if (hq[k].size() > LOCK) void'(hq[k].pop_front());
        if (hq[k].size() == LOCK && qones(hq[k]) == 0) begin nxt = 3; wq[k].delete(); end
      end
      default: if (Vld_i) begin
        wq[k].push_back(e);
        if (qones(wq[k]) >= P_LOSS[k]) begin
          nxt = 2; m_loss[k] = 1; hq[k].delete();
        end else if (wq[k].size() == WIN) begin
          wq[k].delete();
        end
      end
    endcase
    if (Stop) begin nxt = 0; m_loss[k] = 0; end
    m_st[k] = nxt;
  endtask

  task automatic cmp_model();
    chk("A.state", a_st, m_st[0]);
    chk("A.des_en", a_en, m_st[0] != 0);
    chk("A.lock", a_lock, m_st[0] == 3);
    chk("A.loss", a_loss, m_loss[0]);
    chk("A.err", a_err, m_err[0]);
    chk("B.state", b_st, m_st[1]);
    chk("B.des_en", b_en, m_st[1] != 0);
    chk("B.lock", b_lock, m_st[1] == 3);
    chk("B.loss", b_loss, m_loss[1]);
    chk("B.err", b_err, m_err[1]);
  endtask

  task automatic tick();
    @(posedge Ck);
    mdl_step(0);
    mdl_step(1);
    #1;
    cmp_model();
  endtask

  task automatic wrd(input logic [DW-1:0] d);
    Vld_i = 1'b1; Dat_i = d;
    tick();
    Vld_i = 1'b0; Dat_i = '0;
  endtask

  typedef struct {
    bit            rs;
    bit            start;
    bit            vld;
    logic [DW-1:0] dat;
    int            st;
    bit            lock;
  } vec_t;

  function automatic vec_t mk(bit rs, bit start, bit vld, logic [DW-1:0] dat, int st, bit lock);
    vec_t v;
    v.rs = rs; v.start = start; v.vld = vld; v.dat = dat; v.st = st; v.lock = lock;
    return v;
  endfunction

  initial begin
    vec_t tv[$];
    logic [63:0] r64;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
    r64 = '0;
  end

  initial begin
    vec_t tv[$];
    logic [63:0] r64;
    Rs = 1'b0; CE = 1'b1; Start = 1'b1; Stop = 1'b0; Clr = 1'b0; Vld_i = 1'b0; Dat_i = '0;

    // T1 reset then T2 acquisition.
    for (int i = 0; i < 3; i++) tv.push_back(mk(0, 1, 0, '0, 0, 0));
    tv.push_back(mk(1, 1, 0, '0, 1, 0));
    tv.push_back(mk(1, 0, 1, 62'h3, 1, 0));
    tv.push_back(mk(1, 0, 1, 62'h5, 2, 0));
    for (int i = 1; i <= LOCK; i++) tv.push_back(mk(1, 0, 1, '0, (i == LOCK) ? 3 : 2, i == LOCK));
    foreach (tv[i]) begin
      Rs = tv[i].rs; Start = tv[i].start; Vld_i = tv[i].vld; Dat_i = tv[i].dat;
      tick();
      chk("T12.state", a_st, tv[i].st);
      chk("T12.des_en", a_en, tv[i].st != 0);
      chk("T12.lock", a_lock, tv[i].lock);
      chk("T12.loss", a_loss, 0);
      chk("T12.err", a_err, 0);
      chk("T12.b_state", b_st, tv[i].st);
    end
    Start = 1'b0; Vld_i = 1'b0; Dat_i = '0;

    // T3: stop, restart, an errored word inside the hunt restarts the run.
    Stop = 1'b1; tick(); Stop = 1'b0;
    chk("T3.stop_state", a_st, 0);
    chk("T3.stop_des_en", a_en, 0);
    Start = 1'b1; tick(); Start = 1'b0;
    chk("T3.flush_state", a_st, 1);
    wrd('0); wrd('0);
    chk("T3.hunt_state", a_st, 2);
    for (int i = 1; i <= 32; i++) begin
      wrd((i == 16) ? 62'h1 : 62'h0);
      chk("T3.lock", a_lock, i == 32);
    end

    // T4: four errored words in one window force loss.
    Clr = 1'b1; tick(); Clr = 1'b0;
    chk("T4.clr", a_err, 0);
    for (int i = 1; i <= 40; i++) begin
      wrd((i % 10 == 0) ? 62'h3 : 62'h0);
      if (i < 40) chk("T4.lock_held", a_lock, 1);
    end
    chk("T4.loss", a_loss, 1);
    chk("T4.state", a_st, 2);
    chk("T4.err", a_err, 4 * INC3);
    chk("T4.b_err", b_err, 4 * INC3);
    tick();
    chk("T4.loss_pulse", a_loss, 0);

    // T5: three errors per window never accumulate across the boundary.
    for (int i = 1; i <= LOCK; i++) begin
      wrd('0);
      chk("T5.relock", a_lock, i == LOCK);
    end
    Clr = 1'b1; tick(); Clr = 1'b0;
    for (int i = 1; i <= 2 * WIN; i++) begin
      wrd((i >= 5 && i <= 7) || (i >= WIN + 2 && i <= WIN + 4) ? 62'h1 : 62'h0);
      chk("T5.lock", a_lock, 1);
    end
    chk("T5.err", a_err, 6);
    chk("T5.b_err", b_err, 6);

    // T6: saturation, clear priority, stop, stop-over-start, CE freeze.
    Clr = 1'b1; tick(); Clr = 1'b0;
    for (int i = 0; i < 20; i++) wrd(62'h3);
    chk("T6.sat", b_err, 15);
    chk("T6.b_lock", b_lock, 1);
    Clr = 1'b1; wrd(62'h3); Clr = 1'b0;
    chk("T6.clr_prio", b_err, 0);
    wrd(62'h3);
    chk("T6.inc", b_err, INC3);
    Stop = 1'b1; tick(); Stop = 1'b0;
    chk("T6.stop_state", b_st, 0);
    chk("T6.stop_des_en", b_en, 0);
    chk("T6.stop_lock", b_lock, 0);
    chk("T6.stop_keep_err", b_err, INC3);
    Stop = 1'b1; Start = 1'b1; tick(); Stop = 1'b0;
    chk("T6.stop_beats_start", a_st, 0);
    CE = 1'b0; Clr = 1'b1; Vld_i = 1'b1; Dat_i = 62'h3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("T6.ce_state", b_st, 0);
      chk("T6.ce_err", b_err, INC3);
      chk("T6.ce_des_en", a_en, 0);
    end
    CE = 1'b1; Clr = 1'b0; Vld_i = 1'b0; Dat_i = '0;
    tick();
    chk("T6.ce_resume", a_st, 1);
    Start = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      Rs    = ($urandom_range(0, 499) != 0);
      CE    = ($urandom_range(0, 9) != 0);
      Start = ($urandom_range(0, 3) != 0);
      Stop  = ($urandom_range(0, 99) == 0);
      Clr   = ($urandom_range(0, 49) == 0);
      Vld_i = ($urandom_range(0, 4) != 0);
      r64   = {$urandom, $urandom};
      Dat_i = ($urandom_range(0, 9) == 0) ? r64[DW-1:0] : '0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
